icache_dm_array: RTL and testbench

- Parametrised direct-mapped instruction cache: NUM_LINES lines of LINE_BYTES each, with per-line tag and valid bit.
- Serves 32-bit instruction fetches from the CPU. On a miss it refills a full line over a request/ack memory handshake.
- Supports a multi-cycle flush that walks and invalidates every line.
- Sits between the fetch stage and the line-wide memory/L2 port, replacing single-line cache storage.

---
 rtl/icache_dm_array_if.sv | 26 ++
 rtl/icache_dm_array.sv | 189 ++++++++++++++++++
 tb/tb_icache_dm_array.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/icache_dm_array_if.sv
// Fetch-side and line-refill-side signal bundle for icache_dm_array.
// slave = cache view, master = CPU/memory environment view.
interface icache_dm_array_if #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32
);
    logic                      cpu_req;
    logic [ADDR_W-1:0]         cpu_addr;
    logic                      cpu_ready;
    logic [31:0]               cpu_data;
    logic                      cpu_hit;
    logic                      mem_req;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_ack;
    logic [8*LINE_BYTES-1:0]   mem_line;

    modport slave (
        input  cpu_req, cpu_addr, mem_ack, mem_line,
        output cpu_ready, cpu_data, cpu_hit, mem_req, mem_addr
    );

    modport master (
        output cpu_req, cpu_addr, mem_ack, mem_line,
        input  cpu_ready, cpu_data, cpu_hit, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_dm_array.sv
// Direct-mapped instruction cache with line refill handshake and walking flush.
// Optional hit/miss statistics counters are enabled with `define ICACHE_STATS_EN.
module icache_dm_array #(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 32,
    parameter int NUM_LINES  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        flush,
    output logic        busy,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
`endif
    icache_dm_array_if.slave bus
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W = 8 * LINE_BYTES;
    localparam int WORDS  = LINE_BYTES / 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL,
        S_RESP,
        S_FLUSH
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]  req_addr;
    logic [IDX_W-1:0]   flush_idx;
    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]   tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]  data_mem [NUM_LINES];

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [OFF_W-1:0]   req_off;
    logic               lookup_hit;
    logic [31:0]        sel_word;
    logic               flush_go;
    logic               req_go;
    logic               refill_done;

    logic               ready_d, hit_d;
    logic               ready_q, hit_q;
    logic [31:0]        data_q;
    logic               mem_req_c;
    logic [ADDR_W-1:0]  mem_addr_c;

    assign req_tag = req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx = req_addr[IDX_W+OFF_W-1 : OFF_W];
    assign req_off = req_addr[OFF_W-1 : 0];

    assign lookup_hit  = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign refill_done = (state == S_REFILL) && bus.mem_ack;

    // A request is not taken in the cycle cpu_ready is shown, so a CPU that
    // drops cpu_req on seeing ready is never served twice.
    assign flush_go = (state == S_IDLE) && enable && flush;
    assign req_go   = (state == S_IDLE) && enable && !flush && bus.cpu_req && !ready_q;

    // Big-endian word select: word 0 occupies the most significant bits.
    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (i == 32'(req_off >> 2)) begin
                sel_word = data_mem[req_idx][LINE_W-1-32*i -: 32];
            end
        end
    end

    // State register and registered CPU-facing outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            valid     <= '0;
            flush_idx <= '0;
            req_addr  <= '0;
            ready_q   <= 1'b0;
            hit_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= ready_d;
            hit_q   <= hit_d;
            if (ready_d) begin
                data_q <= sel_word;
            end
            if (req_go) begin
                req_addr <= bus.cpu_addr;
            end
            if (flush_go) begin
                flush_idx <= '0;
            end else if (state == S_FLUSH) begin
                flush_idx <= flush_idx + 1'b1;
            end
            if (refill_done) begin
                valid[req_idx] <= 1'b1;
            end else if (state == S_FLUSH) begin
                valid[flush_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && refill_done) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= bus.mem_line;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (flush_go) begin
                    state_nx = S_FLUSH;
                end else if (req_go) begin
                    state_nx = S_LOOKUP;
                end
            end
            S_LOOKUP: state_nx = lookup_hit ? S_IDLE : S_REFILL;
            S_REFILL: begin
                if (bus.mem_ack) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP:   state_nx = S_IDLE;
            S_FLUSH: begin
                if (flush_idx == IDX_W'(NUM_LINES - 1)) begin
                    state_nx = S_IDLE;
                end
            end
            default:  state_nx = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready_d    = 1'b0;
        hit_d      = 1'b0;
        mem_req_c  = 1'b0;
        mem_addr_c = '0;
        busy       = (state != S_IDLE);
        case (state)
            S_LOOKUP: begin
                ready_d = lookup_hit;
                hit_d   = lookup_hit;
            end
            S_REFILL: begin
                mem_req_c  = 1'b1;
                mem_addr_c = {req_tag, req_idx, {OFF_W{1'b0}}};
            end
            S_RESP:   ready_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.cpu_ready = ready_q;
    assign bus.cpu_hit   = hit_q;
    assign bus.cpu_data  = data_q;
    assign bus.mem_req   = mem_req_c;
    assign bus.mem_addr  = mem_addr_c;

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || flush_go) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == S_LOOKUP) begin
            if (lookup_hit) begin
                if (hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + 1'b1;
                end
            end else if (miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm_array.sv
// Directed self-checking bench for icache_dm_array at default parameters.
module tb_icache_dm_array;
    logic clk;
    logic rst;
    logic enable;
    logic flush;
    logic busy;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int unsigned checks;
    int unsigned errors;

    icache_dm_array_if #(.ADDR_W(32), .LINE_BYTES(32)) bus ();

    icache_dm_array #(
        .ADDR_W    (32),
        .LINE_BYTES(32),
        .NUM_LINES (256)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .flush   (flush),
        .busy    (busy),
`ifdef ICACHE_STATS_EN
        .hit_cnt (hit_cnt),
        .miss_cnt(miss_cnt),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line whose byte k (byte 0 = MSB) holds base + k
    function automatic logic [255:0] make_line(input logic [7:0] base);
        logic [255:0] l;
        for (int k = 0; k < 32; k++) begin
            l[255-8*k -: 8] = base + 8'(k);
        end
        return l;
    endfunction

    // Issue one fetch, answer any refill with make_line(base), check the response.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic exp_hit,
                         input logic [31:0] exp_data, input logic [7:0] base);
        int unsigned cyc;
        logic        got_ready;
        logic        saw_mem;
        bus.cpu_addr = addr;
        bus.cpu_req  = 1'b1;
        step();
        bus.cpu_req = 1'b0;
        cyc       = 1;
        got_ready = 1'b0;
        saw_mem   = 1'b0;
        while (!got_ready && cyc < 40) begin
            if (bus.cpu_ready) begin
                got_ready = 1'b1;
            end else begin
                if (bus.mem_req) begin
                    saw_mem = 1'b1;
                    check({tag, ".mem_addr"}, bus.mem_addr, addr & 32'hFFFF_FFE0);
                    bus.mem_line = make_line(base);
                    bus.mem_ack  = 1'b1;
                    step();
                    bus.mem_ack = 1'b0;
                    check({tag, ".mem_req_drop"}, 32'(bus.mem_req), 32'd0);
                end else begin
                    step();
                end
                cyc++;
            end
        end
        check({tag, ".ready"}, 32'(got_ready), 32'd1);
        check({tag, ".hit"}, 32'(bus.cpu_hit), 32'(exp_hit));
        check({tag, ".data"}, bus.cpu_data, exp_data);
        check({tag, ".refill"}, 32'(saw_mem), 32'(!exp_hit));
        if (exp_hit) begin
            check({tag, ".latency"}, cyc, 32'd2);
        end
        step();
        check({tag, ".ready_pulse"}, 32'(bus.cpu_ready), 32'd0);
    endtask

    initial begin
        int unsigned busy_cycles;
        logic        bad;
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        enable       = 1'b1;
        flush        = 1'b0;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        bus.mem_ack  = 1'b0;
        bus.mem_line = '0;
        step();
        step();
        check("rst.ready", 32'(bus.cpu_ready), 32'd0);
        check("rst.hit", 32'(bus.cpu_hit), 32'd0);
        check("rst.data", bus.cpu_data, 32'd0);
        check("rst.mem_req", 32'(bus.mem_req), 32'd0);
        check("rst.mem_addr", bus.mem_addr, 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        fetch("cold", 32'h0000_2004, 1'b0, 32'h0405_0607, 8'h00);
        fetch("warm", 32'h0000_201C, 1'b1, 32'h1C1D_1E1F, 8'h00);

        fetch("evict_new", 32'h0000_4000, 1'b0, 32'h8081_8283, 8'h80);
        fetch("evict_old", 32'h0000_2000, 1'b0, 32'h0001_0203, 8'h00);

        fetch("fill1", 32'h0000_0048, 1'b0, 32'h4849_4A4B, 8'h40);
        fetch("fill2", 32'h0000_0060, 1'b0, 32'h6061_6263, 8'h60);
        fetch("fill_hit", 32'h0000_2010, 1'b1, 32'h1011_1213, 8'h00);

        // Flush and fetch raised together: the flush wins, the fetch waits.
        flush        = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 32'h0000_0048;
        step();
        flush       = 1'b0;
        busy_cycles = 0;
        bad         = 1'b0;
        while (busy && busy_cycles < 1000) begin
            if (bus.mem_req || bus.cpu_ready) bad = 1'b1;
            busy_cycles++;
            step();
        end
        check("flush.cycles", busy_cycles, 32'd256);
        check("flush.quiet", 32'(bad), 32'd0);
        fetch("flush_miss1", 32'h0000_0048, 1'b0, 32'h4849_4A4B, 8'h40);
        fetch("flush_miss2", 32'h0000_0060, 1'b0, 32'h6061_6263, 8'h60);
        fetch("flush_miss3", 32'h0000_2010, 1'b0, 32'h1011_1213, 8'h00);

        // Reset while a refill is outstanding; the late ack must be dropped.
        bus.cpu_addr = 32'h0000_0084;
        bus.cpu_req  = 1'b1;
        step();
        bus.cpu_req = 1'b0;
        step();
        check("rr.mem_req_before", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr.mem_req", 32'(bus.mem_req), 32'd0);
        check("rr.busy", 32'(busy), 32'd0);
        check("rr.mem_addr", bus.mem_addr, 32'd0);
        bus.mem_line = make_line(8'hAA);
        bus.mem_ack  = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        check("rr.busy_after_ack", 32'(busy), 32'd0);
        check("rr.ready_after_ack", 32'(bus.cpu_ready), 32'd0);
        fetch("rr_refetch", 32'h0000_0084, 1'b0, 32'h9495_9697, 8'h90);
        fetch("rr_cleared", 32'h0000_2000, 1'b0, 32'h0001_0203, 8'h00);

        // enable low: held request is never taken
        enable       = 1'b0;
        bus.cpu_addr = 32'h0000_2004;
        bus.cpu_req  = 1'b1;
        bad          = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy || bus.mem_req || bus.cpu_ready) bad = 1'b1;
        end
        check("dis.idle", 32'(bad), 32'd0);
        enable = 1'b1;
        fetch("dis_then_en", 32'h0000_2004, 1'b1, 32'h0405_0607, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete (checks %0d)", checks);
        $fatal(1, "timeout");
    end

endmodule
